// File: rtl/instruction_fetch.sv
// instruction_fetch
//
// Fetch stage of a five-stage pipeline, plus the IF/ID pipeline register and
// a small run-control FSM (IDLE -> RUN -> HALT).
//
// Ports
//   clk         rising-edge system clock
//   reset       synchronous, active-high; returns to IDLE with PC = 0
//   start       level; leaves IDLE for RUN on the next edge
//   StallF      hazard unit: hold the fetch PC
//   StallD      hazard unit: hold the IF/ID register
//   PCSrcD      branch taken (resolved in decode)
//   PCBranchD   branch target; the low two bits are dropped
//   ImemRdata   instruction word, combinational read of ImemAddr
//   ImemAddr    current fetch PC
//   InstrD      IF/ID instruction word
//   PCPlus4D    IF/ID copy of the fetch PC + 4
//   inicio      high outside RUN; forces the control unit to all-zero outputs
//   running     high in RUN
//   halted      high in HALT
//   InstrCount  number of instructions captured into IF/ID (wraps)
module instruction_fetch (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        StallF,
  input  logic        StallD,
  input  logic        PCSrcD,
  input  logic [31:0] PCBranchD,
  input  logic [31:0] ImemRdata,
  output logic [31:0] ImemAddr,
  output logic [31:0] InstrD,
  output logic [31:0] PCPlus4D,
  output logic        inicio,
  output logic        running,
  output logic        halted,
  output logic [31:0] InstrCount
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

  localparam logic [5:0] FINISH_OP = 6'b111110;

  state_t      state;
  logic [31:0] pcf;
  logic [31:0] pcplus4f;
  logic        flush;
  logic        capture;
  logic        finish;

  // PC + 4 wraps naturally at 2^32, so 0xFFFFFFFC rolls over to 0.
  assign pcplus4f = pcf + 32'd4;

  // A taken branch only flushes when the fetch stage is actually moving;
  // a stalled fetch ignores the branch for that cycle.
  assign flush   = PCSrcD && !StallF;
  assign capture = !flush && !StallD;
  assign finish  = (ImemRdata[31:26] == FINISH_OP);

  // Run-control FSM, fetch PC, IF/ID register and instruction counter.
  // Only a real capture into IF/ID counts an instruction or can halt, so a
  // FINISH word that is flushed or held back by StallD has no effect.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      pcf        <= 32'd0;
      InstrD     <= 32'd0;
      PCPlus4D   <= 32'd0;
      InstrCount <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          InstrD   <= 32'd0;
          PCPlus4D <= 32'd0;
          if (start) begin
            state <= RUN;
          end
        end

        RUN: begin
          if (!StallF) begin
            pcf <= PCSrcD ? {PCBranchD[31:2], 2'b00} : pcplus4f;
          end
          if (flush) begin
            InstrD   <= 32'd0;
            PCPlus4D <= 32'd0;
          end else if (capture) begin
            InstrD     <= ImemRdata;
            PCPlus4D   <= pcplus4f;
            InstrCount <= InstrCount + 32'd1;
            if (finish) begin
              state <= HALT;
            end
          end
        end

        HALT: begin
          InstrD   <= 32'd0;
          PCPlus4D <= 32'd0;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Status outputs decode the registered state directly, with no extra delay.
  assign ImemAddr = pcf;
  assign inicio   = (state != RUN);
  assign running  = (state == RUN);
  assign halted   = (state == HALT);

endmodule

// File: tb/tb_instruction_fetch.sv
module tb_instruction_fetch;

  logic        clk;
  logic        reset;
  logic        start;
  logic        StallF;
  logic        StallD;
  logic        PCSrcD;
  logic [31:0] PCBranchD;
  logic [31:0] ImemRdata;
  logic [31:0] ImemAddr;
  logic [31:0] InstrD;
  logic [31:0] PCPlus4D;
  logic        inicio;
  logic        running;
  logic        halted;
  logic [31:0] InstrCount;

  int vectors;
  int miscompares;

  // Instruction memory: every address holds an ADDI word derived from the
  // address, except one address that can be made to hold FINISH.
  logic [31:0] finishAddr;
  logic [25:0] salt;

  assign ImemRdata = (ImemAddr == finishAddr) ? 32'hF8000000
                                              : {6'b001000, ImemAddr[25:0] ^ salt};

  instruction_fetch dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .StallF     (StallF),
    .StallD     (StallD),
    .PCSrcD     (PCSrcD),
    .PCBranchD  (PCBranchD),
    .ImemRdata  (ImemRdata),
    .ImemAddr   (ImemAddr),
    .InstrD     (InstrD),
    .PCPlus4D   (PCPlus4D),
    .inicio     (inicio),
    .running    (running),
    .halted     (halted),
    .InstrCount (InstrCount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model of the fetch block, kept as plain values.
  localparam int M_IDLE = 0;
  localparam int M_RUN  = 1;
  localparam int M_HALT = 2;

  int          mMode;
  logic [31:0] mPc;
  logic [31:0] mInstr;
  logic [31:0] mPlus4;
  logic [31:0] mCount;

  function automatic logic [31:0] memword(input logic [31:0] a);
    return (a == finishAddr) ? 32'hF8000000 : {6'b001000, a[25:0] ^ salt};
  endfunction

  // Advance the model by one clock using the inputs currently driven.
  task automatic model_step();
    logic [31:0] w;
    logic [31:0] nextPc;
    if (reset) begin
      mMode = M_IDLE; mPc = 0; mInstr = 0; mPlus4 = 0; mCount = 0;
    end else if (mMode == M_IDLE) begin
      mInstr = 0; mPlus4 = 0;
      if (start) mMode = M_RUN;
    end else if (mMode == M_HALT) begin
      mInstr = 0; mPlus4 = 0;
    end else begin
      w = memword(mPc);
      if (StallF)      nextPc = mPc;
      else if (PCSrcD) nextPc = PCBranchD & 32'hFFFFFFFC;
      else             nextPc = mPc + 32'd4;
      if (PCSrcD && !StallF) begin
        mInstr = 0; mPlus4 = 0;
      end else if (!StallD) begin
        mInstr = w;
        mPlus4 = mPc + 32'd4;
        mCount = mCount + 32'd1;
        if (w[31:26] == 6'b111110) mMode = M_HALT;
      end
      mPc = nextPc;
    end
  endtask

  // Model one edge, apply it to the DUT, then settle just past the edge.
  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle_inputs();
    start = 0; StallF = 0; StallD = 0; PCSrcD = 0; PCBranchD = 0;
  endtask

  task automatic branch_to(input logic [31:0] target);
    PCSrcD = 1; PCBranchD = target;
    tick();
    PCSrcD = 0; PCBranchD = 0;
  endtask

  task automatic test_reset();
    set_idle_inputs();
    reset = 1;
    tick();
    tick();
    reset = 0;
    vectors++;
    if ({inicio, running, halted, ImemAddr, InstrD, InstrCount} !== {1'b1, 1'b0, 1'b0, 96'd0}) begin
      miscompares++;
      $display("[TB] FAIL reset_state: got inicio=%b running=%b halted=%b addr=%h instr=%h cnt=%0d, want 1 0 0 0 0 0",
               inicio, running, halted, ImemAddr, InstrD, InstrCount);
    end
  endtask

  task automatic test_fetch();
    start = 1;
    tick();
    start = 0;
    vectors++;
    if ({running, inicio, ImemAddr} !== {1'b1, 1'b0, 32'd0}) begin
      miscompares++;
      $display("[TB] FAIL start_run: got running=%b inicio=%b addr=%h, want 1 0 0", running, inicio, ImemAddr);
    end
    for (int k = 1; k <= 3; k++) begin
      tick();
      vectors++;
      if ({ImemAddr, InstrD, PCPlus4D, InstrCount} !==
          {32'(4 * k), memword(32'(4 * (k - 1))), 32'(4 * k), 32'(k)}) begin
        miscompares++;
        $display("[TB] FAIL seq_fetch_%0d: got addr=%h instr=%h p4=%h cnt=%0d, want addr=%h instr=%h p4=%h cnt=%0d",
                 k, ImemAddr, InstrD, PCPlus4D, InstrCount,
                 32'(4 * k), memword(32'(4 * (k - 1))), 32'(4 * k), k);
      end
    end
  endtask

  task automatic test_branch();
    branch_to(32'h00000043);
    vectors++;
    if ({ImemAddr, InstrD, PCPlus4D, InstrCount} !== {32'h40, 32'h0, 32'h0, 32'd3}) begin
      miscompares++;
      $display("[TB] FAIL branch_flush: got addr=%h instr=%h p4=%h cnt=%0d, want 40 0 0 3",
               ImemAddr, InstrD, PCPlus4D, InstrCount);
    end
  endtask

  task automatic test_stall();
    logic [31:0] heldInstr;
    logic [31:0] heldCount;
    branch_to(32'h00000010);
    heldInstr = InstrD;
    heldCount = InstrCount;
    StallF = 1; StallD = 1; PCSrcD = 1; PCBranchD = 32'h00000080;
    for (int k = 0; k < 2; k++) begin
      tick();
      vectors++;
      if ({ImemAddr, InstrD, InstrCount} !== {32'h10, heldInstr, heldCount}) begin
        miscompares++;
        $display("[TB] FAIL stall_hold_%0d: got addr=%h instr=%h cnt=%0d, want 10 %h %0d",
                 k, ImemAddr, InstrD, InstrCount, heldInstr, heldCount);
      end
    end
    set_idle_inputs();
    tick();
    vectors++;
    if ({ImemAddr, InstrD, InstrCount} !== {32'h14, memword(32'h10), heldCount + 32'd1}) begin
      miscompares++;
      $display("[TB] FAIL stall_release: got addr=%h instr=%h cnt=%0d, want 14 %h %0d",
               ImemAddr, InstrD, InstrCount, memword(32'h10), heldCount + 32'd1);
    end
  endtask

  task automatic test_finish();
    finishAddr = 32'h20;
    branch_to(32'h00000020);
    tick();
    vectors++;
    if ({InstrD, halted, inicio, running, ImemAddr} !== {32'hF8000000, 1'b1, 1'b1, 1'b0, 32'h24}) begin
      miscompares++;
      $display("[TB] FAIL finish_halt: got instr=%h halted=%b inicio=%b running=%b addr=%h, want f8000000 1 1 0 24",
               InstrD, halted, inicio, running, ImemAddr);
    end
    for (int k = 0; k < 3; k++) begin
      start = 1; StallF = 1'($urandom); StallD = 1'($urandom); PCSrcD = 1; PCBranchD = $urandom;
      tick();
      vectors++;
      if ({ImemAddr, InstrD, PCPlus4D, halted, running} !== {32'h24, 32'h0, 32'h0, 1'b1, 1'b0}) begin
        miscompares++;
        $display("[TB] FAIL halt_frozen_%0d: got addr=%h instr=%h p4=%h halted=%b running=%b, want 24 0 0 1 0",
                 k, ImemAddr, InstrD, PCPlus4D, halted, running);
      end
    end
    set_idle_inputs();
    finishAddr = 32'h1;
  endtask

  task automatic test_reset_midrun();
    reset = 1; tick(); reset = 0;
    start = 1; tick(); start = 0;
    branch_to(32'h00000030);
    tick();
    reset = 1;
    tick();
    reset = 0;
    vectors++;
    if ({ImemAddr, InstrD, InstrCount, inicio, running, halted} !== {96'd0, 1'b1, 1'b0, 1'b0}) begin
      miscompares++;
      $display("[TB] FAIL reset_midrun: got addr=%h instr=%h cnt=%0d inicio=%b running=%b halted=%b, want 0 0 0 1 0 0",
               ImemAddr, InstrD, InstrCount, inicio, running, halted);
    end
  endtask

  task automatic test_wrap();
    start = 1; tick(); start = 0;
    branch_to(32'hFFFFFFFC);
    tick();
    vectors++;
    if ({ImemAddr, PCPlus4D, InstrD} !== {32'h0, 32'h0, memword(32'hFFFFFFFC)}) begin
      miscompares++;
      $display("[TB] FAIL pc_wrap: got addr=%h p4=%h instr=%h, want 0 0 %h",
               ImemAddr, PCPlus4D, InstrD, memword(32'hFFFFFFFC));
    end
  endtask

  task automatic test_random();
    reset = 1; set_idle_inputs(); tick(); reset = 0;
    for (int n = 0; n < 400; n++) begin
      reset     = ($urandom_range(99, 0) < 2);
      start     = ($urandom_range(99, 0) < 30);
      StallF    = ($urandom_range(99, 0) < 20);
      StallD    = ($urandom_range(99, 0) < 20);
      PCSrcD    = ($urandom_range(99, 0) < 15);
      PCBranchD = $urandom;
      finishAddr = ($urandom_range(99, 0) < 6) ? mPc : 32'h1;
      tick();
      vectors++;
      if ({ImemAddr, InstrD, PCPlus4D, InstrCount, running, halted, inicio} !==
          {mPc, mInstr, mPlus4, mCount, mMode == M_RUN, mMode == M_HALT, mMode != M_RUN}) begin
        miscompares++;
        $display("[TB] FAIL random_%0d: got addr=%h instr=%h p4=%h cnt=%h run=%b halt=%b, want addr=%h instr=%h p4=%h cnt=%h mode=%0d",
                 n, ImemAddr, InstrD, PCPlus4D, InstrCount, running, halted,
                 mPc, mInstr, mPlus4, mCount, mMode);
      end
    end
    reset = 0;
    set_idle_inputs();
    finishAddr = 32'h1;
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    finishAddr = 32'h1;
    salt = 26'($urandom);
    reset = 1;
    set_idle_inputs();
    mMode = M_IDLE; mPc = 0; mInstr = 0; mPlus4 = 0; mCount = 0;
    @(negedge clk);
    test_reset();
    test_fetch();
    test_branch();
    test_stall();
    test_finish();
    test_reset_midrun();
    test_wrap();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
